// File: rtl/risc_controller_pkg.sv
// risc_controller_pkg: opcodes, phase encoding and opcode grouping shared by controller and ALU
package risc_controller_pkg;
   localparam logic [2:0] OP_HLT = 3'b000;
   localparam logic [2:0] OP_SKZ = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_AND = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_LDA = 3'b101;
   localparam logic [2:0] OP_STO = 3'b110;
   localparam logic [2:0] OP_JMP = 3'b111;
   typedef enum logic [2:0] {
      INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE
   } phase_t;
   function automatic logic is_alu_op(input logic [2:0] op);
      return op inside {OP_ADD, OP_AND, OP_XOR, OP_LDA};
   endfunction
endpackage

// File: rtl/risc_controller_phase_counter.sv
// phase_counter: 3-bit wrapping phase counter with async clear and hold
module phase_counter (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       hold,
   output logic [2:0] count
);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) count <= 3'd0;
      else if (!hold) count <= count + 3'd1;
endmodule

// File: rtl/risc_controller.sv
// risc_controller: eight-phase sequencer decoding opcode into datapath strobes
module risc_controller
   import risc_controller_pkg::*;
#(
   parameter bit HALT_STICKY = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] opcode,
   input  logic       zero,
   output logic       sel,
   output logic       rd,
   output logic       wr,
   output logic       ld_ir,
   output logic       ld_ac,
   output logic       inc_pc,
   output logic       ld_pc,
   output logic       data_e,
   output logic       halt,
   output logic [2:0] phase
);
   logic   halted;
   logic   alu;
   logic   run;
   phase_t ph;
   phase_counter u_phase (.clk(clk), .rst_n(rst_n), .hold(halted), .count(phase));
   assign ph = phase_t'(phase);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) halted <= 1'b0;
      else if (HALT_STICKY && ph == OP_ADDR && opcode == OP_HLT) halted <= 1'b1;
   // once halted every strobe except halt is forced low
   always_comb begin
      alu    = is_alu_op(opcode);
      run    = !halted;
      sel    = run && ph inside {INST_ADDR, INST_FETCH, INST_LOAD, IDLE};
      rd     = run && (ph inside {INST_FETCH, INST_LOAD, IDLE} ||
                       (alu && ph inside {OP_FETCH, ALU_OP, STORE}));
      ld_ir  = run && ph inside {INST_LOAD, IDLE};
      inc_pc = run && (ph == OP_ADDR || (ph == ALU_OP && opcode == OP_SKZ && zero));
      ld_pc  = run && opcode == OP_JMP && ph inside {ALU_OP, STORE};
      data_e = run && opcode == OP_STO && ph inside {ALU_OP, STORE};
      wr     = run && opcode == OP_STO && ph == STORE;
      ld_ac  = run && alu && ph == STORE;
      halt   = halted || (ph == OP_ADDR && opcode == OP_HLT);
   end
endmodule

// File: tb/tb_risc_controller.sv
// tb_risc_controller: scoreboard bench driving directed opcode sequences through risc_controller
module tb_risc_controller;
   import risc_controller_pkg::*;
   typedef struct packed {
      logic [2:0] p;
      logic [8:0] s;
   } exp_t;
   // strobe order: sel rd wr ld_ir ld_ac inc_pc ld_pc data_e halt
   localparam logic [8:0] FRONT [4] = '{
      9'b1_0_0_0_0_0_0_0_0, 9'b1_1_0_0_0_0_0_0_0,
      9'b1_1_0_1_0_0_0_0_0, 9'b1_1_0_1_0_0_0_0_0};
   localparam logic [8:0] TAIL [5][4] = '{
      '{9'b0_0_0_0_0_1_0_0_0, 9'b0_1_0_0_0_0_0_0_0, 9'b0_1_0_0_0_0_0_0_0, 9'b0_1_0_0_1_0_0_0_0},
      '{9'b0_0_0_0_0_1_0_0_0, 9'b0_0_0_0_0_0_0_0_0, 9'b0_0_0_0_0_0_0_1_0, 9'b0_0_1_0_0_0_0_1_0},
      '{9'b0_0_0_0_0_1_0_0_0, 9'b0_0_0_0_0_0_0_0_0, 9'b0_0_0_0_0_1_0_0_0, 9'b0_0_0_0_0_0_0_0_0},
      '{9'b0_0_0_0_0_1_0_0_0, 9'b0_0_0_0_0_0_0_0_0, 9'b0_0_0_0_0_0_0_0_0, 9'b0_0_0_0_0_0_0_0_0},
      '{9'b0_0_0_0_0_1_0_0_0, 9'b0_0_0_0_0_0_0_0_0, 9'b0_0_0_0_0_0_1_0_0, 9'b0_0_0_0_0_0_1_0_0}};
   localparam logic [8:0] RST_V  = 9'b1_0_0_0_0_0_0_0_0;
   localparam logic [8:0] HLT4_V = 9'b0_0_0_0_0_1_0_0_1;
   localparam logic [8:0] HLTD_V = 9'b0_0_0_0_0_0_0_0_1;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] opcode = OP_ADD;
   logic       zero = 1'b0;
   logic       sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt;
   logic [2:0] phase;
   exp_t       q[$];
   int         errors = 0;
   int         checks = 0;
   int         n = 0;
   event       smp;
   risc_controller dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .sel(sel), .rd(rd), .wr(wr),
      .ld_ir(ld_ir), .ld_ac(ld_ac), .inc_pc(inc_pc), .ld_pc(ld_pc), .data_e(data_e),
      .halt(halt), .phase(phase)
   );
   always #5 clk = ~clk;
   initial forever begin
      exp_t e;
      exp_t g;
      @(negedge clk or smp);
      if (q.size() > 0) begin
         e = q.pop_front();
         g = {phase, sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt};
         checks++;
         if (g !== e) begin
            errors++;
            $display("FAIL vec%0d phase/strobes got=%b_%b exp=%b_%b", n, g.p, g.s, e.p, e.s);
         end
         checks++;
         if (inc_pc && ld_pc) begin
            errors++;
            $display("FAIL excl%0d inc_pc=%b ld_pc=%b exp not both 1", n, inc_pc, ld_pc);
         end
         n++;
      end
   end
   task automatic step(input logic [2:0] p, input logic [8:0] s);
      q.push_back({p, s});
      @(posedge clk);
      #1;
   endtask
   task automatic run(input logic [2:0] op, input logic z, input int t);
      opcode = op;
      zero   = z;
      for (int p = 0; p < 4; p++) step(3'(p), FRONT[p]);
      for (int p = 0; p < 4; p++) step(3'(p + 4), TAIL[t][p]);
   endtask
   task automatic async_reset();
      rst_n = 1'b0;
      #1;
      q.push_back({3'd0, RST_V});
      -> smp;
      #1;
   endtask
   initial begin
      @(posedge clk);
      #1;
      opcode = OP_STO;
      step(3'd0, RST_V);
      rst_n = 1'b1;
      run(OP_ADD, 1'b0, 0);
      run(OP_STO, 1'b0, 1);
      run(OP_SKZ, 1'b1, 2);
      run(OP_SKZ, 1'b0, 3);
      run(OP_JMP, 1'b1, 4);
      opcode = OP_STO;
      for (int p = 0; p < 4; p++) step(3'(p), FRONT[p]);
      for (int p = 0; p < 3; p++) step(3'(p + 4), TAIL[1][p]);
      q.push_back({3'd7, TAIL[1][3]});
      @(negedge clk);
      #2;
      async_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      opcode = OP_HLT;
      for (int p = 0; p < 4; p++) step(3'(p), FRONT[p]);
      step(3'd4, HLT4_V);
      for (int i = 0; i < 20; i++) step(3'd5, HLTD_V);
      #1;
      async_reset();
      rst_n = 1'b1;
      step(3'd0, RST_V);
      opcode = OP_ADD;
      step(3'd1, FRONT[1]);
      step(3'd2, FRONT[2]);
      for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
      #1;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d exp=0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
   initial begin
      #100000;
      $display("FAIL watchdog timeout got=running exp=finished");
      $fatal(1);
   end
endmodule
